uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- UART receive stage; the downstream counterpart of uart_transmitter.
- Consumes the serial line (8N1, LSB first, idle high) and recovers bytes by sampling at mid-bit.
- Presents each byte on a valid/ack handshake to the command logic inside top.
- Flags framing errors and overruns.

Parameters:
- DVSR, 347, clock cycles per bit (40 MHz / 115200); must be ≥ 4.
- WORD_SIZE, 8, data bits per frame.

Ports:
- clk  in  1  system clock (clk40M domain).
- rst  in  1  synchronous, active-high reset.
- serialIn  in  1  asynchronous serial line, idle high.
- rxData  out  WORD_SIZE  last received word, LSB = first data bit.
- rxValid  out  1  rxData holds an unread word; held until acked.
- rxAck  in  1  consumer read strobe; honoured only while rxValid=1.
- frameErr  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: new word written while previous still unread.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - rxData=0, rxValid=0, frameErr=0, overrun=0.
  - Synchronizer flops=1, state=IDLE, counters=0.
- Input sync: 2-flop synchronizer on serialIn; all logic uses the 2nd flop output (rxS). This adds 2 cycles of latency.
- Counters:
  - baudCnt is $clog2(DVSR) bits wide; runs 0..DVSR-1 and wraps to 0.
  - bitIdx is $clog2(WORD_SIZE+1) bits wide.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rxS=0 -> START, baudCnt=0.
  - START: at baudCnt==(DVSR-1)/2, sample rxS.
    - Sample 0 -> DATA, baudCnt=0, bitIdx=0.
    - Sample 1 -> IDLE (glitch rejected, no outputs).
  - DATA: at baudCnt==DVSR-1, shift rxS into the MSB of shiftReg (right shift, so LSB-first ends aligned), then baudCnt=0 and bitIdx++. After WORD_SIZE samples -> STOP.
  - STOP: at baudCnt==DVSR-1, sample rxS.
    - Sample 1: rxData<=shiftReg and rxValid<=1 on the next edge; -> IDLE.
    - Sample 0: frameErr pulses 1 cycle; rxData/rxValid unchanged; -> WAIT_HIGH.
  - WAIT_HIGH: stay until rxS=1, then -> IDLE. A held-low line must not retrigger reception.
- Handshake:
  - rxAck with rxValid=1 clears rxValid on the next edge.
  - rxAck with rxValid=0 is ignored.
- Simultaneous events:
  - New-word load in the same cycle as rxAck: the load wins, rxValid stays 1, no overrun.
  - New-word load while rxValid=1 and no rxAck: rxData overwritten, rxValid stays 1, overrun pulses 1 cycle.
- Latency:
  - rxValid rises (DVSR-1)/2 + (WORD_SIZE+1)·DVSR + 3 cycles after the first clk where serialIn is low at the synchronizer input (±1 for async alignment).
  - With DVSR=16, WORD_SIZE=8 this is 7+144+3 = 154 cycles.
- Reset mid-frame: rst aborts immediately to the reset values; no partial word or error pulse is emitted. Reception resumes on the next falling edge after rst deasserts.
- Outputs are registered; there is no combinational path from serialIn or rxAck to any output.

Decomposition:
- Shared package uart_pkg holds:
  - the enum type uart_rx_state_t {IDLE, START, DATA, STOP, WAIT_HIGH};
  - localparam UART_IDLE_LVL = 1'b1.
- The package is shared with uart_transmitter for line-level constants.
- One sub-module: sync_2ff (2-flop synchronizer with RESET_VAL parameter = 1), reusable for the spi/miso inputs.
- Baud counter and FSM stay inline.

Test Plan (DVSR=16, WORD_SIZE=8, driven by uart_transmitter with the same DVSR):
- Single word: send 0xAB, rxAck tied 0 -> rxValid=1, rxData=0xAB, frameErr=0, overrun=0. Pulse rxAck -> rxValid=0 next cycle.
- Back-to-back without ack: send 0xA1 then 0xA0 -> after the 2nd frame rxData=0xA0, rxValid=1, exactly one overrun pulse.
- Ack collision: send 0xA1; pulse rxAck in the exact cycle the 2nd word 0xA1 loads -> rxValid stays 1, overrun=0.
- Glitch rejection: drive serialIn low for 4 cycles, then high -> FSM returns to IDLE, with no rxValid, frameErr or overrun over 200 cycles.
- Framing error:
  - Drive a frame of 0xD1 with the stop bit low, then hold the line low for 40 cycles -> frameErr pulses once, rxValid stays 0, no second frame is started.
  - Then idle high and send 0xD0 -> rxData=0xD0, rxValid=1.
- Reset mid-frame: assert rst for 1 cycle during data bit 3 of 0xAB -> all outputs 0. The remainder of the frame produces no rxValid/frameErr beyond the glitch path, and the next clean 0xAB is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Line-level constants and receiver state encoding, shared by the UART rx and tx blocks.
// Latency: none (package only).
// Backpressure: none (package only).
package uart_pkg;

    // Level of the serial line when no frame is in flight; also the stop-bit level.
    localparam logic UART_IDLE_LVL = 1'b1;

    // Receiver frame-tracking states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer that brings an asynchronous single-bit input into the clk domain.
// Latency: 2 clk cycles from din to dout.
// Backpressure: none; samples every cycle.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic metaFlop;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            metaFlop <= RESET_VAL;
            dout     <= RESET_VAL;
        end else begin
            metaFlop <= din;
            dout     <= metaFlop;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receiver: mid-bit sampling, valid/ack word hand-off, framing-error and overrun pulses.
// Latency: (DVSR-1)/2 + (WORD_SIZE+1)*DVSR + 3 clk from serialIn falling to rxValid rising.
// Backpressure: none on the line; an unread word is overwritten by the next one and overrun pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DVSR      = 347,  // clk cycles per bit, at least 4
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serialIn,
    output logic [WORD_SIZE-1:0] rxData,
    output logic                 rxValid,
    input  logic                 rxAck,
    output logic                 frameErr,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(DVSR);
    localparam int IDX_W = $clog2(WORD_SIZE + 1);

    // Start bit is checked half a bit in; every later sample is a whole bit after the previous one.
    localparam logic [CNT_W-1:0] BAUD_MID  = CNT_W'((DVSR - 1) / 2);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DVSR - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_SIZE - 1);

    logic                 rxS;
    uart_rx_state_t       state;
    uart_rx_state_t       stateNext;
    logic [CNT_W-1:0]     baudCnt;
    logic [CNT_W-1:0]     baudCntNext;
    logic [IDX_W-1:0]     bitIdx;
    logic [IDX_W-1:0]     bitIdxNext;
    logic [WORD_SIZE-1:0] shiftReg;
    logic [WORD_SIZE-1:0] shiftRegNext;
    logic                 loadWord;
    logic                 stopBad;

    sync_2ff #(
        .RESET_VAL (UART_IDLE_LVL)
    ) uSyncRx (
        .clk  (clk),
        .rst  (rst),
        .din  (serialIn),
        .dout (rxS)
    );

    // Frame-tracking registers: state, baud counter, bit index and data shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudCntNext;
            bitIdx   <= bitIdxNext;
            shiftReg <= shiftRegNext;
        end
    end

    // Next-state logic: walk start, data and stop bits, deciding load or framing error at the stop bit.
    always_comb begin
        stateNext    = state;
        baudCntNext  = baudCnt;
        bitIdxNext   = bitIdx;
        shiftRegNext = shiftReg;
        loadWord     = 1'b0;
        stopBad      = 1'b0;

        case (state)
            IDLE: begin
                baudCntNext = '0;
                if (rxS != UART_IDLE_LVL) begin
                    stateNext = START;
                end
            end

            START: begin
                if (baudCnt == BAUD_MID) begin
                    baudCntNext = '0;
                    bitIdxNext  = '0;
                    // A line already back high by mid start bit was a glitch, not a frame.
                    stateNext   = (rxS != UART_IDLE_LVL) ? DATA : IDLE;
                end else begin
                    baudCntNext = baudCnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (baudCnt == BAUD_LAST) begin
                    baudCntNext  = '0;
                    // Right shift so the first (LSB) bit ends up in bit 0 after WORD_SIZE samples.
                    shiftRegNext = {rxS, shiftReg[WORD_SIZE-1:1]};
                    bitIdxNext   = bitIdx + IDX_W'(1);
                    if (bitIdx == IDX_LAST) begin
                        stateNext = STOP;
                    end
                end else begin
                    baudCntNext = baudCnt + CNT_W'(1);
                end
            end

            STOP: begin
                if (baudCnt == BAUD_LAST) begin
                    baudCntNext = '0;
                    if (rxS == UART_IDLE_LVL) begin
                        loadWord  = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        stopBad   = 1'b1;
                        stateNext = WAIT_HIGH;
                    end
                end else begin
                    baudCntNext = baudCnt + CNT_W'(1);
                end
            end

            WAIT_HIGH: begin
                // A line stuck low after a bad stop bit must not look like a new start bit.
                baudCntNext = '0;
                if (rxS == UART_IDLE_LVL) begin
                    stateNext = IDLE;
                end
            end

            default: begin
                stateNext   = IDLE;
                baudCntNext = '0;
            end
        endcase
    end

    // Consumer-facing outputs: a fresh load beats a same-cycle ack; overwriting an unread word flags overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxData   <= '0;
            rxValid  <= 1'b0;
            frameErr <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            frameErr <= stopBad;
            overrun  <= loadWord && rxValid && !rxAck;
            if (loadWord) begin
                rxData  <= shiftReg;
                rxValid <= 1'b1;
            end else if (rxAck) begin
                rxValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized and directed bench for uart_receiver against a word-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_receiver;

    localparam int DVSR      = 16;
    localparam int WORD_SIZE = 8;
    localparam int FRAME_CYC = (WORD_SIZE + 2) * DVSR;
    localparam int LATENCY   = (DVSR - 1) / 2 + (WORD_SIZE + 1) * DVSR + 3;

    logic                 clk40M;
    logic                 rst;
    logic                 serialIn;
    logic [WORD_SIZE-1:0] rxData;
    logic                 rxValid;
    logic                 rxAck;
    logic                 frameErr;
    logic                 overrun;

    uart_receiver #(
        .DVSR      (DVSR),
        .WORD_SIZE (WORD_SIZE)
    ) dut (
        .clk      (clk40M),
        .rst      (rst),
        .serialIn (serialIn),
        .rxData   (rxData),
        .rxValid  (rxValid),
        .rxAck    (rxAck),
        .frameErr (frameErr),
        .overrun  (overrun)
    );

    initial clk40M = 1'b0;
    always #5 clk40M = ~clk40M;

    int totalCnt = 0;
    int badCnt   = 0;

    // Event counters observed on the falling edge, away from the sampling edge.
    int cyc      = 0;
    int errCnt   = 0;
    int ovrCnt   = 0;
    int riseCyc  = -1;
    logic prevValid = 1'b0;

    always @(posedge clk40M) cyc <= cyc + 1;

    always @(negedge clk40M) begin
        if (frameErr === 1'b1) errCnt = errCnt + 1;
        if (overrun === 1'b1) ovrCnt = ovrCnt + 1;
        if (rxValid === 1'b1 && prevValid !== 1'b1) riseCyc = cyc;
        prevValid = rxValid;
    end

    // Word-level reference model: what the consumer should see after each whole frame.
    logic [7:0] mdlData  = 8'h00;
    logic       mdlValid = 1'b0;
    int         mdlErr   = 0;
    int         mdlOvr   = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic mdlFrame(input logic [7:0] d, input bit stopOk, input bit ackSame);
        if (stopOk) begin
            if (mdlValid && !ackSame) mdlOvr++;
            mdlData  = d;
            mdlValid = 1'b1;
        end else begin
            mdlErr++;
        end
    endtask

    task automatic mdlAck();
        mdlValid = 1'b0;
    endtask

    task automatic checkModel(input string tag);
        checkVal({tag, ".data"},  32'(rxData),  32'(mdlData));
        checkVal({tag, ".valid"}, 32'(rxValid), 32'(mdlValid));
        checkVal({tag, ".ferr"},  32'(errCnt),  32'(mdlErr));
        checkVal({tag, ".ovr"},   32'(ovrCnt),  32'(mdlOvr));
    endtask

    // Drive one frame from a falling edge; ackAt/rstAt pulse those inputs at a frame-relative cycle.
    int startCyc;
    task automatic driveFrame(input logic [7:0] d, input bit stopBit, input int ackAt, input int rstAt);
        startCyc = cyc;
        for (int k = 0; k < FRAME_CYC; k++) begin
            int b;
            b = k / DVSR;
            if (b == 0)      serialIn = 1'b0;
            else if (b == 9) serialIn = stopBit;
            else             serialIn = d[b-1];
            rxAck = (k == ackAt);
            rst   = (k == rstAt);
            if (rstAt >= 0 && k == rstAt + 1) begin
                checkVal("rstmid.valid", 32'(rxValid), 32'd0);
                checkVal("rstmid.data",  32'(rxData),  32'd0);
                checkVal("rstmid.ferr",  32'(frameErr), 32'd0);
                checkVal("rstmid.ovr",   32'(overrun), 32'd0);
            end
            @(negedge clk40M);
        end
        rxAck = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic idleLine(input int n);
        serialIn = 1'b1;
        rxAck    = 1'b0;
        repeat (n) @(negedge clk40M);
    endtask

    task automatic ackPulse();
        rxAck = 1'b1;
        @(negedge clk40M);
        rxAck = 1'b0;
        mdlAck();
    endtask

    initial begin
        int errBefore;
        int ovrBefore;

        serialIn = 1'b1;
        rxAck    = 1'b0;
        rst      = 1'b1;
        repeat (3) @(negedge clk40M);
        checkVal("reset.valid", 32'(rxValid),  32'd0);
        checkVal("reset.data",  32'(rxData),   32'd0);
        checkVal("reset.ferr",  32'(frameErr), 32'd0);
        checkVal("reset.ovr",   32'(overrun),  32'd0);
        rst = 1'b0;
        idleLine(5);

        // Single word, then ack clears valid on the next edge.
        driveFrame(8'hAB, 1'b1, -1, -1);
        mdlFrame(8'hAB, 1'b1, 1'b0);
        checkVal("single.latency", 32'(riseCyc - startCyc - 1), 32'(LATENCY));
        checkModel("single");
        ackPulse();
        checkVal("single.ackclr", 32'(rxValid), 32'd0);
        idleLine(4);

        // Back-to-back frames, no ack: second overwrites and raises one overrun.
        driveFrame(8'hA1, 1'b1, -1, -1);
        mdlFrame(8'hA1, 1'b1, 1'b0);
        driveFrame(8'hA0, 1'b1, -1, -1);
        mdlFrame(8'hA0, 1'b1, 1'b0);
        idleLine(4);
        checkModel("b2b");

        // Ack lands in the very cycle the next word loads: load wins, no overrun.
        driveFrame(8'hA1, 1'b1, LATENCY, -1);
        mdlFrame(8'hA1, 1'b1, 1'b1);
        idleLine(4);
        checkModel("collide");
        ackPulse();
        idleLine(4);

        // Short low glitch is rejected at mid start bit.
        serialIn = 1'b0;
        repeat (4) @(negedge clk40M);
        idleLine(200);
        checkModel("glitch");

        // Bad stop bit with the line held low afterwards: one error, no retrigger.
        driveFrame(8'hD1, 1'b0, -1, -1);
        mdlFrame(8'hD1, 1'b0, 1'b0);
        repeat (40) @(negedge clk40M);
        checkModel("ferr");
        idleLine(10);
        driveFrame(8'hD0, 1'b1, -1, -1);
        mdlFrame(8'hD0, 1'b1, 1'b0);
        idleLine(4);
        checkModel("ferr.recover");

        // Random frames: random data, occasional bad stop bits, random acks and gaps.
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            bit stopOk;
            d      = 8'($urandom);
            stopOk = ($urandom_range(0, 3) != 0);
            driveFrame(d, stopOk, -1, -1);
            mdlFrame(d, stopOk, 1'b0);
            if (!stopOk) repeat ($urandom_range(0, 20)) @(negedge clk40M);
            idleLine($urandom_range(2, 30));
            checkModel($sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) begin
                ackPulse();
                idleLine(2);
            end
        end

        // Reset in the middle of data bit 3 with an unread word pending.
        driveFrame(8'h5C, 1'b1, -1, -1);
        idleLine(4);
        errBefore = errCnt;
        ovrBefore = ovrCnt;
        driveFrame(8'hAB, 1'b1, -1, 4 * DVSR + DVSR / 2);
        idleLine(200);
        checkVal("rstmid.noferr", 32'(errCnt), 32'(errBefore));
        ackPulse();
        idleLine(4);
        mdlErr   = errBefore;
        mdlOvr   = ovrBefore;
        driveFrame(8'hAB, 1'b1, -1, -1);
        mdlFrame(8'hAB, 1'b1, 1'b0);
        idleLine(4);
        checkModel("rstmid.next");

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule
